ppt_sequencer: RTL and testbench
================================

# ppt_sequencer

Firing sequencer for the pulsed plasma thruster (PPT). It takes the configuration fields published by the I2C register map (clock divider, period, width, count, run) and generates the thruster fire pulse train. It reports completed firings and completion status back to the register map's read-only COUNT_DONE and DONE fields. It is the only block that drives the thruster trigger output.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock (32.768 kHz oscillator domain)
- rst  in  1  asynchronous, active-high reset
- clk_div  in  5  prescaler exponent; tick period = 2^(clk_div+1) clk cycles
- period  in  16  firing period in ticks
- width  in  16  fire pulse width in ticks
- count  in  16  number of firings per run
- run_ppt  in  1  run request level from register map
- fire  out  1  registered thruster trigger
- busy  out  1  high while a run is in progress
- count_done  out  16  completed firings in current/last run
- done  out  1  sticky run-complete flag

## Operation
- Reset values: state IDLE, fire=0, busy=0, count_done=0, done=0, prescaler=0, pcnt=0.
- FSM states are IDLE, RUN and DONE.
- **IDLE to RUN**: taken when run_ppt=1 is sampled.
  - On that edge: snapshot clk_div, period, width and count into internal registers.
  - Also on that edge: prescaler=0, pcnt=0, count_done=0, done=0, busy=1.
  - Snapshot rule: input changes during RUN are ignored.
- **count=0 at start**: IDLE goes directly to DONE with count_done=0 and done=1; no pulse is produced.
- **Prescaler**: 32-bit free-running counter, active only in RUN.
  - tick = low (clk_div_s+1) bits of prescaler all ones. The counter wraps naturally.
- **Period counter pcnt** (16 bit), on a tick:
  - If pcnt == period_eff-1: pcnt=0 and count_done+1. If the new count_done equals count_s, go to DONE.
  - Otherwise pcnt+1.
  - period_eff = max(period_s,1); period=0 behaves as 1.
- **fire**: register, next value = (next state is RUN) && (next pcnt < width_s).
  - width=0: no pulse, but periods are still counted.
  - width >= period_eff: fire stays high continuously for the whole run.
- **RUN to DONE**: on the final tick, the same edge sets fire=0, busy=0, done=1 and count_done=count_s.
- **DONE**: holds until run_ppt=0, then goes to IDLE. done stays 1 and count_done holds.
  - A new run therefore needs run_ppt to go low, then high.
- **Abort**: run_ppt=0 sampled in RUN goes to IDLE on that edge.
  - fire=0, busy=0, done stays 0, count_done holds the partial value.
- **Reset mid-run**: immediate return to reset values, fire=0 asynchronously.
- Arithmetic: count_done is compared against count_s for equality, so no overflow is possible. count=65535 is legal.

## Timing
- Start edge E0 (run_ppt sampled high in IDLE): fire=1 is visible after E0 if width_s>0.
- Let T = 2^(clk_div_s+1) clk cycles.
  - Pulse high time = min(width_s, period_eff)·T cycles exactly.
  - Pulse repetition = period_eff·T cycles.
- Completion edge = E0 + count_s·period_eff·T. done and count_done update on that edge.
- Abort latency: fire drops on the first edge sampling run_ppt=0.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Basic run**: clk_div=0, period=4, width=1, count=3, run_ppt pulse high.
  - fire is high 2 cycles and low 6 cycles, repeated 3 times.
  - done=1 and count_done=3 at E0+24; busy falls at the same edge.
- **Abort**: clk_div=0, period=4, width=2, count=10; drop run_ppt at E0+17.
  - fire=0 on the next edge, count_done=2, done=0, FSM back in IDLE.
- **Degenerate settings**:
  - count=0 gives done=1 one edge after start and no fire.
  - width=0, period=2, count=2 gives no fire and done at E0+8.
  - width=5, period=3, count=2 gives fire high continuously for 12 cycles.
- **Snapshot**: start with period=4, width=1, count=2, then change period to 100 and width to 50 at E0+3.
  - Timing is unchanged; done at E0+16.
- **Reset and restart**:
  - rst asserted mid-pulse gives fire=0 immediately and all outputs at reset values.
  - After DONE, holding run_ppt high does not restart. Going low then high clears done and count_done and starts a new run.
- **Default config**: clk_div=9, period=128, width=1, count=16.
  - Pulse is 1024 cycles wide with a 131072-cycle period.
  - done after 2,097,152 cycles; sample check with a shortened count=2.

Source files
------------

// File: rtl/ppt_sequencer.sv
// ppt_sequencer: firing sequencer for the pulsed plasma thruster.
// It captures the run configuration at start, divides the clock into ticks,
// counts ticks into firing periods, drives the registered fire output,
// and reports completed firings and sticky completion back to the register map.
module ppt_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  clk_div,
    input  logic [15:0] period,
    input  logic [15:0] width,
    input  logic [15:0] count,
    input  logic        run_ppt,
    output logic        fire,
    output logic        busy,
    output logic [15:0] count_done,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state, state_next;

    // Configuration captured at the start edge; later input changes are ignored.
    logic [4:0]  clk_div_s, clk_div_s_next;
    logic [15:0] period_s, period_s_next;
    logic [15:0] width_s, width_s_next;
    logic [15:0] count_s, count_s_next;

    logic [31:0] prescaler, prescaler_next;
    logic [15:0] pcnt, pcnt_next;

    logic        fire_next;
    logic        busy_next;
    logic [15:0] count_done_next;
    logic        done_next;

    logic [31:0] tick_mask;
    logic        tick;
    logic [15:0] period_last;
    logic [15:0] count_done_inc;

    // A tick fires whenever the low (clk_div_s+1) prescaler bits are all ones.
    // Shifting ...FE left and inverting gives a mask that saturates cleanly at clk_div_s=31.
    assign tick_mask      = ~(32'hFFFF_FFFE << clk_div_s);
    assign tick           = ((prescaler & tick_mask) == tick_mask);
    // period=0 is treated as a one-tick period.
    assign period_last    = (period_s == 16'd0) ? 16'd0 : (period_s - 16'd1);
    assign count_done_inc = count_done + 16'd1;

    // Next-state and next-register logic; every target gets its hold value first.
    always_comb begin
        state_next      = state;
        clk_div_s_next  = clk_div_s;
        period_s_next   = period_s;
        width_s_next    = width_s;
        count_s_next    = count_s;
        prescaler_next  = prescaler;
        pcnt_next       = pcnt;
        busy_next       = busy;
        count_done_next = count_done;
        done_next       = done;

        case (state)
            S_IDLE: begin
                if (run_ppt) begin
                    clk_div_s_next  = clk_div;
                    period_s_next   = period;
                    width_s_next    = width;
                    count_s_next    = count;
                    prescaler_next  = 32'd0;
                    pcnt_next       = 16'd0;
                    count_done_next = 16'd0;
                    if (count == 16'd0) begin
                        // Nothing to fire: complete immediately.
                        state_next = S_DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = S_RUN;
                        busy_next  = 1'b1;
                        done_next  = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (!run_ppt) begin
                    // Abort: keep the partial count, leave done clear.
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                end else begin
                    prescaler_next = prescaler + 32'd1;
                    if (tick) begin
                        if (pcnt == period_last) begin
                            pcnt_next       = 16'd0;
                            count_done_next = count_done_inc;
                            if (count_done_inc == count_s) begin
                                state_next = S_DONE;
                                busy_next  = 1'b0;
                                done_next  = 1'b1;
                            end
                        end else begin
                            pcnt_next = pcnt + 16'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                // Wait for the run request to drop so a new run needs a fresh rising level.
                if (!run_ppt) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase

        // Fire is a pure function of where the sequencer will be after this edge.
        fire_next = (state_next == S_RUN) && (pcnt_next < width_s_next);
    end

    // State and datapath registers with asynchronous reset to the idle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            clk_div_s  <= 5'd0;
            period_s   <= 16'd0;
            width_s    <= 16'd0;
            count_s    <= 16'd0;
            prescaler  <= 32'd0;
            pcnt       <= 16'd0;
            fire       <= 1'b0;
            busy       <= 1'b0;
            count_done <= 16'd0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            clk_div_s  <= clk_div_s_next;
            period_s   <= period_s_next;
            width_s    <= width_s_next;
            count_s    <= count_s_next;
            prescaler  <= prescaler_next;
            pcnt       <= pcnt_next;
            fire       <= fire_next;
            busy       <= busy_next;
            count_done <= count_done_next;
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_ppt_sequencer.sv
// tb_ppt_sequencer: directed self-checking bench for the PPT firing sequencer.
// Expected waveforms come from the timing relations of the sequencer:
// tick period T = 2^(clk_div+1), pulse high for min(width,period_eff)*T cycles,
// repetition period_eff*T, completion at count*period_eff*T after the start edge.
module tb_ppt_sequencer;

    logic        clk;
    logic        rst;
    logic [4:0]  clk_div;
    logic [15:0] period;
    logic [15:0] width;
    logic [15:0] count;
    logic        run_ppt;
    logic        fire;
    logic        busy;
    logic [15:0] count_done;
    logic        done;

    int passed;
    int total;

    ppt_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .period     (period),
        .width      (width),
        .count      (count),
        .run_ppt    (run_ppt),
        .fire       (fire),
        .busy       (busy),
        .count_done (count_done),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report tag/observed/expected on a miss.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a run from IDLE and check every cycle up to and past completion.
    // If chg is set, period/width are disturbed 3 cycles after the start edge.
    task automatic check_run(input string name, input int cd, input int per,
                             input int wid, input int cnt, input bit chg);
        int t, pe, hi, rep, tot;
        t   = 1 << (cd + 1);
        pe  = (per == 0) ? 1 : per;
        hi  = ((wid < pe) ? wid : pe) * t;
        rep = pe * t;
        tot = cnt * rep;
        clk_div = 5'(cd);
        period  = 16'(per);
        width   = 16'(wid);
        count   = 16'(cnt);
        run_ppt = 1'b1;
        step();  // start edge E0
        for (int k = 0; k < tot; k++) begin
            chk({name, "_fire"}, 32'(fire), ((k % rep) < hi) ? 32'd1 : 32'd0);
            chk({name, "_busy"}, 32'(busy), 32'd1);
            chk({name, "_done"}, 32'(done), 32'd0);
            chk({name, "_cnt"},  32'(count_done), 32'(k / rep));
            if (chg && k == 3) begin
                period = 16'd100;
                width  = 16'd50;
            end
            step();
        end
        chk({name, "_end_fire"}, 32'(fire), 32'd0);
        chk({name, "_end_busy"}, 32'(busy), 32'd0);
        chk({name, "_end_done"}, 32'(done), 32'd1);
        chk({name, "_end_cnt"},  32'(count_done), 32'(cnt));
        // Holding run_ppt high must not restart.
        for (int k = 0; k < 3; k++) begin
            step();
            chk({name, "_hold_fire"}, 32'(fire), 32'd0);
            chk({name, "_hold_busy"}, 32'(busy), 32'd0);
            chk({name, "_hold_done"}, 32'(done), 32'd1);
            chk({name, "_hold_cnt"},  32'(count_done), 32'(cnt));
        end
        $display("run %s clk_div=%0d period=%0d width=%0d count=%0d cycles=%0d checks=%0d/%0d",
                 name, cd, per, wid, cnt, tot, passed, total);
    endtask

    // Drop run_ppt and let DONE fall back to IDLE; done and count_done stay.
    task automatic release_run(input string name, input int cnt);
        run_ppt = 1'b0;
        step();
        chk({name, "_rel_done"}, 32'(done), 32'd1);
        chk({name, "_rel_cnt"},  32'(count_done), 32'(cnt));
        chk({name, "_rel_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst     = 1'b1;
        clk_div = 5'd0;
        period  = 16'd0;
        width   = 16'd0;
        count   = 16'd0;
        run_ppt = 1'b0;
        step();
        step();
        chk("reset_fire", 32'(fire), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_cnt",  32'(count_done), 32'd0);
        rst = 1'b0;
        step();
        $display("reset checks=%0d/%0d", passed, total);

        // Basic run, then restart after going low and high again.
        check_run("basic", 0, 4, 1, 3, 1'b0);
        release_run("basic", 3);
        check_run("restart", 0, 4, 1, 3, 1'b0);
        release_run("restart", 3);

        // Abort: drop run_ppt after E0+17.
        clk_div = 5'd0; period = 16'd4; width = 16'd2; count = 16'd10;
        run_ppt = 1'b1;
        step();
        for (int k = 0; k < 17; k++) step();
        chk("abort_fire_before", 32'(fire), 32'd1);
        run_ppt = 1'b0;
        step();
        chk("abort_fire", 32'(fire), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_cnt",  32'(count_done), 32'd2);
        // Back in IDLE: a new request starts immediately.
        run_ppt = 1'b1;
        step();
        chk("abort_idle_busy", 32'(busy), 32'd1);
        chk("abort_idle_cnt",  32'(count_done), 32'd0);
        chk("abort_idle_fire", 32'(fire), 32'd1);
        run_ppt = 1'b0;
        step();
        $display("abort checks=%0d/%0d", passed, total);

        // count=0: done one edge after start, no pulse.
        count = 16'd0; period = 16'd4; width = 16'd2;
        run_ppt = 1'b1;
        step();
        chk("cnt0_done", 32'(done), 32'd1);
        chk("cnt0_cnt",  32'(count_done), 32'd0);
        chk("cnt0_fire", 32'(fire), 32'd0);
        chk("cnt0_busy", 32'(busy), 32'd0);
        step();
        chk("cnt0_fire_hold", 32'(fire), 32'd0);
        release_run("cnt0", 0);
        $display("count0 checks=%0d/%0d", passed, total);

        // Degenerate widths and snapshot behaviour.
        check_run("width0", 0, 2, 0, 2, 1'b0);
        release_run("width0", 2);
        check_run("widebig", 0, 3, 5, 2, 1'b0);
        release_run("widebig", 2);
        check_run("snapshot", 0, 4, 1, 2, 1'b1);
        release_run("snapshot", 2);
        check_run("period0", 1, 0, 1, 3, 1'b0);
        release_run("period0", 3);
        // Default prescaler (1024-cycle tick) with a shortened period.
        check_run("dflt_div", 9, 4, 1, 2, 1'b0);
        release_run("dflt_div", 2);

        // Reset in the middle of a pulse: outputs clear without a clock edge.
        clk_div = 5'd0; period = 16'd4; width = 16'd2; count = 16'd5;
        run_ppt = 1'b1;
        step();
        for (int k = 0; k < 9; k++) step();
        chk("rst_pre_fire", 32'(fire), 32'd1);
        chk("rst_pre_cnt",  32'(count_done), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_fire", 32'(fire), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt",  32'(count_done), 32'd0);
        run_ppt = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("rst_after_fire", 32'(fire), 32'd0);
        $display("reset_midrun checks=%0d/%0d", passed, total);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
